// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults for the RAM-backed FIFO controller.
// Widths, depth, occupancy width and almost-full/empty levels.
package fifo_ctrl_pkg;
  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 4;
  localparam int DEPTH_DEF    = 1 << ADDR_W_DEF;
  localparam int CNT_W_DEF    = ADDR_W_DEF + 1;
  localparam int AF_LEVEL_DEF = 14;
  localparam int AE_LEVEL_DEF = 2;
endpackage

// File: rtl/dual_port_ram.sv
// 16x8 dual-port RAM, synchronous write and 1-cycle synchronous read.
// Ports: clk; port A/B each with we, addr, din, dout.
module dual_port_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b
);
  logic [DATA_W-1:0] mem [1<<ADDR_W];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
  end
endmodule

// File: rtl/fifo_ptr.sv
// Wrap-around FIFO pointer with increment enable.
// Ports: clk, rst (async high), inc, ptr.
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (inc) ptr <= ptr + W'(1);
  end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a dual_port_ram (A = write, B = read).
// Ports: push/pop side, status flags, RAM A/B port signals.
// Option RAM_FIFO_CTRL_LEVEL_FLAGS_EN adds almost_full/almost_empty.
module ram_fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
`ifdef RAM_FIFO_CTRL_LEVEL_FLAGS_EN
  ,
  parameter int AF_LEVEL = AF_LEVEL_DEF,
  parameter int AE_LEVEL = AE_LEVEL_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
`ifdef RAM_FIFO_CTRL_LEVEL_FLAGS_EN
  output logic              almost_full,
  output logic              almost_empty,
`endif
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_din_a,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_din_b,
  input  logic [DATA_W-1:0] ram_dout_b
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic push_ok, pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // Full: pop wins; empty: push wins. Never R/W one address at once.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  fifo_ptr #(.W(ADDR_W)) u_wr (
    .clk(clk), .rst(rst), .inc(push_ok), .ptr(ram_addr_a)
  );
  fifo_ptr #(.W(ADDR_W)) u_rd (
    .clk(clk), .rst(rst), .inc(pop_ok), .ptr(ram_addr_b)
  );

  assign ram_we_a  = push_ok;
  assign ram_din_a = push_data;
  assign ram_we_b  = 1'b0;
  assign ram_din_b = '0;
  assign pop_data  = ram_dout_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= pop_ok;
      if (push & full)  overflow  <= 1'b1;
      if (pop & empty)  underflow <= 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef RAM_FIFO_CTRL_LEVEL_FLAGS_EN
  localparam logic [ADDR_W:0] AF_CNT = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT = (ADDR_W+1)'(AE_LEVEL);

  // Registered from count, so they trail count by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count >= AF_CNT);
      almost_empty <= (count <= AE_CNT);
    end
  end
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl wired to dual_port_ram.
// Checks reset, ordering, full/empty corners, wrap and mid-run reset.
module tb_ram_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic [7:0] push_data = '0;
  logic       pop = 1'b0;
  logic [7:0] pop_data;
  logic       pop_valid, full, empty, overflow, underflow;
  logic [4:0] count;
  logic       we_a, we_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] din_a, din_b, dout_a, dout_b;
`ifdef RAM_FIFO_CTRL_LEVEL_FLAGS_EN
  logic       almost_full, almost_empty;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid),
    .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow),
`ifdef RAM_FIFO_CTRL_LEVEL_FLAGS_EN
    .almost_full(almost_full), .almost_empty(almost_empty),
`endif
    .ram_we_a(we_a), .ram_addr_a(addr_a), .ram_din_a(din_a),
    .ram_we_b(we_b), .ram_addr_b(addr_b), .ram_din_b(din_b),
    .ram_dout_b(dout_b)
  );

  dual_port_ram #(.DATA_W(8), .ADDR_W(4)) ram (
    .clk(clk),
    .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
    .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request levels; returns 1ns after the edge.
  task automatic cyc(input logic p, input logic [7:0] d, input logic q);
    push = p; push_data = d; pop = q;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; #1; rst = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    cyc(1'b0, 8'h00, 1'b1);
    chk({tag, "_pv"}, pop_valid, 1);
    chk({tag, "_data"}, pop_data, exp);
  endtask

  logic [7:0] exp_q [$];

  initial begin
    // Reset and idle
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_pv", pop_valid, 0);
    chk("rst_we_a", we_a, 0);
    chk("rst_we_b", we_b, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

    // Basic ordering
    cyc(1'b1, 8'hEA, 1'b0);
    cyc(1'b1, 8'h12, 1'b0);
    cyc(1'b1, 8'h32, 1'b0);
    chk("basic_count3", count, 3);
    pop_chk("basic0", 8'hEA);
    chk("basic_count2", count, 2);
    pop_chk("basic1", 8'h12);
    pop_chk("basic2", 8'h32);
    chk("basic_count0", count, 0);
    chk("basic_empty", empty, 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("basic_pv_drop", pop_valid, 0);

    // Fill to full, then rejected push
    do_reset();
    chk("fill_addr0", addr_a, 0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    push = 1'b1; push_data = 8'h77; #1;
    chk("fill_we_blocked", we_a, 0);
    @(posedge clk); #1; push = 1'b0;
    chk("fill_ovf", overflow, 1);
    chk("fill_count_hold", count, 16);
    chk("fill_wrptr", addr_a, 0);

    // Wrap: pop 4, push 4, drain all
    for (int i = 0; i < 4; i++) pop_chk("wrap_pop", 8'(i));
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0);
    chk("wrap_count", count, 16);
    exp_q = {};
    for (int i = 4; i < 16; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hA0 + 8'(i));
    foreach (exp_q[i]) pop_chk("wrap_drain", exp_q[i]);
    chk("wrap_empty", empty, 1);

    // Simultaneous push+pop at count=5
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b0);
    cyc(1'b1, 8'hC0, 1'b1);
    chk("pp5_count", count, 5);
    chk("pp5_pv", pop_valid, 1);
    chk("pp5_data", pop_data, 8'hB0);
    pop_chk("pp5_d1", 8'hB1);
    pop_chk("pp5_d2", 8'hB2);
    pop_chk("pp5_d3", 8'hB3);
    pop_chk("pp5_d4", 8'hB4);
    pop_chk("pp5_d5", 8'hC0);
    chk("pp5_empty", empty, 1);
    chk("pp5_no_ovf", overflow, 0);

    // Simultaneous push+pop while empty
    cyc(1'b1, 8'hD0, 1'b1);
    chk("ppe_count", count, 1);
    chk("ppe_unf", underflow, 1);
    chk("ppe_pv", pop_valid, 0);
    pop_chk("ppe_data", 8'hD0);

    // Simultaneous push+pop while full
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
    cyc(1'b1, 8'hEE, 1'b1);
    chk("ppf_count", count, 15);
    chk("ppf_ovf", overflow, 1);
    chk("ppf_unf", underflow, 0);
    chk("ppf_data", pop_data, 8'h10);
    pop_chk("ppf_next", 8'h11);

    // Reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0);
    pop_chk("mid0", 8'h50);
    pop_chk("mid1", 8'h51);
    chk("mid_count6", count, 6);
    pop = 1'b1;
    rst = 1'b1; #1;
    chk("mid_count0", count, 0);
    chk("mid_empty", empty, 1);
    chk("mid_pv", pop_valid, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_unf", underflow, 0);
    pop = 1'b0; rst = 1'b0;
    cyc(1'b1, 8'hFF, 1'b0);
    pop_chk("mid_ff", 8'hFF);
    chk("mid_end_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
